// File: rtl/lights_seq_pkg.sv
// Shared definitions for the lights pattern sequencer.
//   seq_state_e : sequencer FSM states
//   END_BIT, HOLD_LSB, HOLD_MSB, LED_MSB : field positions inside a pattern-table word
//   hold_field  : extracts the hold count from a table word, promoting 0 to 1
package lights_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    localparam int END_BIT  = 31;
    localparam int HOLD_MSB = 30;
    localparam int HOLD_LSB = 18;
    localparam int LED_MSB  = 17;

    localparam int HOLD_FIELD_W = HOLD_MSB - HOLD_LSB + 1;

    // A stored hold of zero behaves exactly like a hold of one tick.
    function automatic logic [HOLD_FIELD_W-1:0] hold_field(input logic [31:0] word);
        logic [HOLD_FIELD_W-1:0] raw;
        raw = word[HOLD_MSB:HOLD_LSB];
        if (raw == {HOLD_FIELD_W{1'b0}}) begin
            return HOLD_FIELD_W'(1);
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/lights_tick_gen.sv
// Hold-time prescaler: asserts tick for one cycle every TICK_DIV cycles.
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   clr     : synchronous clear; counting restarts from 0 on the cycle after clr drops
//   tick    : high in the last cycle of each TICK_DIV-cycle period
module lights_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Prescaler counter: cleared while idle/not holding, wraps at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/lights_pattern_sequencer.sv
// Avalon-MM read master that walks an LED pattern table in on-chip RAM.
// Each table word: [31] end flag, [30:18] hold ticks, [17:0] LED value.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start, stop, loop   : run control (stop beats start)
//   base_addr           : first table word, sampled on an accepted start
//   mem_*               : Avalon-MM read-only master toward the RAM (1-cycle read latency)
//   duty                : PWM duty (only when LIGHTS_SEQ_PWM_EN is defined)
//   leds, busy, done    : LED drive, run active, end-of-run pulse
// Optional feature: define LIGHTS_SEQ_PWM_EN to dim the LEDs with an 8-bit PWM.
module lights_pattern_sequencer
    import lights_seq_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int LED_W    = 18,
    parameter int HOLD_W   = 13,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
`ifdef LIGHTS_SEQ_PWM_EN
    input  logic [7:0]        duty,
`endif
    output logic [LED_W-1:0]  leds,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_r, state_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic [ADDR_W-1:0] base_r, base_nxt;
    logic [HOLD_W-1:0] hold_r, hold_nxt;
    logic              end_r, end_nxt;
    logic [LED_W-1:0]  led_r, led_nxt;
    logic              cs_r, busy_r, done_r, done_nxt;
    logic              tick_s, clr_s;

    // The prescaler only runs in HOLD, so it is at zero on every HOLD entry.
    assign clr_s = (state_r != ST_HOLD);

    lights_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_s),
        .tick    (tick_s)
    );

    // Next-state and datapath decode for the fetch/latch/hold sequence.
    always_comb begin
        state_nxt = state_r;
        addr_nxt  = addr_r;
        base_nxt  = base_r;
        hold_nxt  = hold_r;
        end_nxt   = end_r;
        led_nxt   = led_r;
        done_nxt  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_FETCH;
                    addr_nxt  = base_addr;
                    base_nxt  = base_addr;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    led_nxt   = mem_readdata[LED_W-1:0];
                    hold_nxt  = HOLD_W'(hold_field(mem_readdata));
                    end_nxt   = mem_readdata[END_BIT];
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (tick_s) begin
                    if (hold_r <= HOLD_W'(1)) begin
                        // Hold expired: advance, loop back, or finish.
                        if (!end_r) begin
                            addr_nxt  = addr_r + ADDR_W'(1);
                            state_nxt = ST_FETCH;
                        end else if (loop) begin
                            addr_nxt  = base_r;
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        hold_nxt = hold_r - HOLD_W'(1);
                    end
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            base_r  <= {ADDR_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            end_r   <= 1'b0;
            led_r   <= {LED_W{1'b0}};
            cs_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            addr_r  <= addr_nxt;
            base_r  <= base_nxt;
            hold_r  <= hold_nxt;
            end_r   <= end_nxt;
            led_r   <= led_nxt;
            cs_r    <= (state_nxt == ST_FETCH);
            busy_r  <= (state_nxt != ST_IDLE);
            done_r  <= done_nxt;
        end
    end

    assign mem_address    = addr_r;
    assign mem_chipselect = cs_r;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_writedata  = 32'h0000_0000;
    assign mem_clken      = 1'b1;
    assign busy           = busy_r;
    assign done           = done_r;

`ifdef LIGHTS_SEQ_PWM_EN
    logic [7:0] pwm_cnt_r;

    // Free-running PWM counter; LEDs are lit while it is below duty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt_r <= 8'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
    end

    assign leds = led_r & {LED_W{(pwm_cnt_r < duty)}};
`else
    assign leds = led_r;
`endif

endmodule

// File: tb/tb_lights_pattern_sequencer.sv
module tb_lights_pattern_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start, stop, loop;
    logic [9:0]  base_addr;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata, mem_readdata;
    logic [17:0] leds;
    logic        busy, done;
`ifdef LIGHTS_SEQ_PWM_EN
    logic [7:0]  duty;
`endif

    lights_pattern_sequencer #(
        .ADDR_W(10), .LED_W(18), .HOLD_W(13), .TICK_DIV(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .loop           (loop),
        .base_addr      (base_addr),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
`ifdef LIGHTS_SEQ_PWM_EN
        .duty           (duty),
`endif
        .leds           (leds),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one cycle of read latency.
    logic [31:0] ram [0:1023];
    initial mem_readdata = 32'h0;
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int          scn;
        int          off;
        int          abs_cyc;
        logic [17:0] leds;
        logic        busy;
        logic        done;
        logic        cs;
        logic        chk_addr;
        logic [9:0]  addr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   done_seen  = 0;

    function automatic vec_t mk(int scn, int off, logic [17:0] l, logic b, logic d,
                                logic c, logic ca, logic [9:0] a);
        vec_t v;
        v.scn = scn; v.off = off; v.abs_cyc = 0; v.leds = l; v.busy = b;
        v.done = d; v.cs = c; v.chk_addr = ca; v.addr = a;
        return v;
    endfunction

    function automatic logic [31:0] word(logic e, logic [12:0] h, logic [17:0] l);
        return {e, h, l};
    endfunction

    task automatic push_scn(input int scn, input int t0);
        vec_t v;
        foreach (tbl[i]) begin
            if (tbl[i].scn == scn) begin
                v = tbl[i];
                v.abs_cyc = t0 + v.off;
                sb_q.push_back(v);
            end
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expected checkpoints never reached, required 0", sb_q.size());
            mismatched += sb_q.size();
            compared   += sb_q.size();
            sb_q.delete();
        end
    endtask

    // Scoreboard: pop checkpoints whose cycle has come and compare on the falling edge.
    always @(negedge clk) begin
        vec_t e;
        if (done === 1'b1) done_seen++;
        while (sb_q.size() > 0 && sb_q[0].abs_cyc <= cyc) begin
            e = sb_q.pop_front();
            compared++;
            if (e.abs_cyc != cyc || leds !== e.leds || busy !== e.busy || done !== e.done ||
                mem_chipselect !== e.cs || (e.chk_addr && mem_address !== e.addr) ||
                mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_writedata !== 32'h0 ||
                mem_clken !== 1'b1) begin
                mismatched++;
                $display("FAIL scn%0d+%0d: got leds=%h busy=%b done=%b cs=%b addr=%0d we=%b be=%h, want leds=%h busy=%b done=%b cs=%b addr=%0d(chk=%b)",
                         e.scn, e.off, leds, busy, done, mem_chipselect, mem_address,
                         mem_write, mem_byteenable, e.leds, e.busy, e.done, e.cs, e.addr, e.chk_addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; base_addr = 10'd0;
`ifdef LIGHTS_SEQ_PWM_EN
        duty = 8'd255;
`endif
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;

        // scn, off, leds, busy, done, cs, chk_addr, addr
        tbl.push_back(mk(0,  0, 18'h0,     1'b0, 1'b0, 1'b0, 1'b1, 10'd0));
        // Basic run
        tbl.push_back(mk(1,  1, 18'h0,     1'b1, 1'b0, 1'b1, 1'b1, 10'd0));
        tbl.push_back(mk(1,  2, 18'h0,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(1,  3, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(1, 10, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(1, 11, 18'h1,     1'b1, 1'b0, 1'b1, 1'b1, 10'd1));
        tbl.push_back(mk(1, 12, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(1, 13, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(1, 24, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(1, 25, 18'h3FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(1, 26, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        // Loop, stop, start+stop, reset mid-FETCH
        tbl.push_back(mk(2,  1, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0));
        tbl.push_back(mk(2,  3, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(2, 13, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(2, 24, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(2, 25, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0));
        tbl.push_back(mk(2, 27, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(2, 36, 18'h1,     1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(2, 37, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(2, 41, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(2, 42, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(2, 60, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(2, 63, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(2, 64, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(2, 71, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'd5));
        tbl.push_back(mk(2, 72, 18'h0,     1'b0, 1'b0, 1'b0, 1'b1, 10'd0));
        // Address wrap-around
        tbl.push_back(mk(3,  1, 18'h0,     1'b1, 1'b0, 1'b1, 1'b1, 10'd1023));
        tbl.push_back(mk(3,  3, 18'h5,     1'b1, 1'b0, 1'b0, 1'b1, 10'd1023));
        tbl.push_back(mk(3,  6, 18'h5,     1'b1, 1'b0, 1'b0, 1'b1, 10'd1023));
        tbl.push_back(mk(3,  7, 18'h5,     1'b1, 1'b0, 1'b1, 1'b1, 10'd0));
        tbl.push_back(mk(3,  9, 18'hA,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(3, 12, 18'hA,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(3, 13, 18'hA,     1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(3, 14, 18'hA,     1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
        // Zero hold, plus a start while busy
        tbl.push_back(mk(4,  1, 18'hA,     1'b1, 1'b0, 1'b1, 1'b1, 10'd0));
        tbl.push_back(mk(4,  3, 18'h7,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(4,  6, 18'h7,     1'b1, 1'b0, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(4,  7, 18'h7,     1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(4,  8, 18'h7,     1'b0, 1'b0, 1'b0, 1'b0, 10'd0));

        // Reset state
        goto(3);
        push_scn(0, 3);
        goto(4);
        reset_n = 1'b1;
        drain();

        // Scenario 1: basic run
        ram[0] = word(1'b0, 13'd2, 18'h00001);
        ram[1] = word(1'b1, 13'd3, 18'h3FFFF);
        goto(cyc + 2);
        loop = 1'b0; base_addr = 10'd0; t0 = cyc;
        push_scn(1, t0);
        start = 1'b1;
        goto(t0 + 1); start = 1'b0;
        drain();

        // Scenario 2: loop, abort, start+stop, reset mid-FETCH
        goto(cyc + 2);
        loop = 1'b1; base_addr = 10'd0; t0 = cyc;
        push_scn(2, t0);
        start = 1'b1;
        goto(t0 + 1);  start = 1'b0;
        goto(t0 + 40); stop = 1'b1;
        goto(t0 + 41); stop = 1'b0; loop = 1'b0;
        goto(t0 + 62); start = 1'b1; stop = 1'b1;
        goto(t0 + 63); start = 1'b0; stop = 1'b0;
        goto(t0 + 70); base_addr = 10'd5; start = 1'b1;
        goto(t0 + 71); start = 1'b0; reset_n = 1'b0;
        goto(t0 + 72); reset_n = 1'b1;
        drain();

        // Scenario 3: wrap-around 1023 -> 0
        ram[1023] = word(1'b0, 13'd1, 18'h5);
        ram[0]    = word(1'b1, 13'd1, 18'hA);
        goto(cyc + 2);
        base_addr = 10'd1023; t0 = cyc;
        push_scn(3, t0);
        start = 1'b1;
        goto(t0 + 1); start = 1'b0;
        drain();

        // Scenario 4: zero hold behaves like one tick
        ram[0] = word(1'b1, 13'd0, 18'h7);
        goto(cyc + 2);
        base_addr = 10'd0; t0 = cyc;
        push_scn(4, t0);
        start = 1'b1;
        goto(t0 + 1); start = 1'b0;
        goto(t0 + 4); base_addr = 10'd9; start = 1'b1;
        goto(t0 + 5); start = 1'b0;
        drain();

        goto(cyc + 3);
        compared++;
        if (done_seen != 3) begin
            mismatched++;
            $display("FAIL done_count: got %0d pulses, want 3", done_seen);
        end

`ifdef LIGHTS_SEQ_PWM_EN
        begin
            int lit;
            ram[0] = word(1'b1, 13'h1FFF, 18'h3FFFF);
            base_addr = 10'd0; duty = 8'd64;
            goto(cyc + 1);
            t0 = cyc; start = 1'b1;
            goto(t0 + 1); start = 1'b0;
            goto(t0 + 10);
            lit = 0;
            for (int i = 0; i < 256; i++) begin
                if (leds == 18'h3FFFF) lit++;
                goto(cyc + 1);
            end
            compared++;
            if (lit != 64) begin
                mismatched++;
                $display("FAIL pwm_duty64: got %0d lit cycles, want 64", lit);
            end
            duty = 8'd0;
            goto(cyc + 1);
            lit = 0;
            for (int i = 0; i < 256; i++) begin
                if (leds != 18'h0) lit++;
                goto(cyc + 1);
            end
            compared++;
            if (lit != 0) begin
                mismatched++;
                $display("FAIL pwm_duty0: got %0d lit cycles, want 0", lit);
            end
            stop = 1'b1;
            goto(cyc + 1); stop = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
